// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if
// Bundles every non-clock/reset signal of the pipeline hazard controller.
//   master : pipeline/environment side; drives the ID/EX/MEM status and
//            the backing-memory ack, and observes the control outputs.
//   slave  : the controller itself.
// Signals:
//   id_rs1_i, id_rs2_i  ID-stage source registers
//   ex_memread_i        EX-stage instruction is a load
//   ex_rd_i             EX-stage destination register
//   branch_taken_i      branch resolved taken in ID this cycle
//   dcache_req_i        MEM-stage load/store access
//   dcache_hit_i        that access hits this cycle
//   mem_ack_i           backing memory completed the refill
//   mem_req_o           refill request to backing memory
//   pc_write_o          PC update enable
//   ifid_stall_o        IF/ID hold
//   ifid_flush_o        IF/ID instruction zeroed
//   idex_bubble_o       ID/EX control fields zeroed
//   mem_stall_o         whole-pipeline freeze
//   state_o             refill FSM state (debug)
//   stall_cnt_o         saturating stall-cycle counter
//   err_o               sticky refill timeout flag
interface pipeline_hazard_ctrl_if;
    logic [4:0]  id_rs1_i;
    logic [4:0]  id_rs2_i;
    logic        ex_memread_i;
    logic [4:0]  ex_rd_i;
    logic        branch_taken_i;
    logic        dcache_req_i;
    logic        dcache_hit_i;
    logic        mem_ack_i;
    logic        mem_req_o;
    logic        pc_write_o;
    logic        ifid_stall_o;
    logic        ifid_flush_o;
    logic        idex_bubble_o;
    logic        mem_stall_o;
    logic [1:0]  state_o;
    logic [15:0] stall_cnt_o;
    logic        err_o;

    modport master (
        output id_rs1_i, id_rs2_i, ex_memread_i, ex_rd_i, branch_taken_i,
               dcache_req_i, dcache_hit_i, mem_ack_i,
        input  mem_req_o, pc_write_o, ifid_stall_o, ifid_flush_o,
               idex_bubble_o, mem_stall_o, state_o, stall_cnt_o, err_o
    );

    modport slave (
        input  id_rs1_i, id_rs2_i, ex_memread_i, ex_rd_i, branch_taken_i,
               dcache_req_i, dcache_hit_i, mem_ack_i,
        output mem_req_o, pc_write_o, ifid_stall_o, ifid_flush_o,
               idex_bubble_o, mem_stall_o, state_o, stall_cnt_o, err_o
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Hazard/stall controller for a 5-stage pipeline: load-use interlock,
// taken-branch flush, and a data-cache refill FSM that freezes the whole
// pipeline while a miss is serviced.
// Ports:
//   clk_i  rising-edge clock
//   rst_i  asynchronous, active-high reset
//   bus    pipeline_hazard_ctrl_if.slave (all status inputs and control
//          outputs, see the interface file)
// Parameter:
//   TIMEOUT  REQ cycles without mem_ack_i before the request is dropped for
//            one cycle and retried (1..256).
//
// Refill handshake: mem_req_o is a level, high for every cycle the FSM is in
// REQ. The request completes on the rising edge where mem_ack_i is sampled
// high while mem_req_o is high; mem_ack_i is ignored in any other state.
module pipeline_hazard_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    pipeline_hazard_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2
    } state_e;

    // Last wait-counter value before a timeout fires.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_e      state_q;
    state_e      state_d;
    logic [7:0]  wait_q;
    logic        retry_q;
    logic        err_q;
    logic [15:0] stall_cnt_q;

    logic        miss;
    logic        hazard;
    logic        timeout;
    logic        mem_stall;

    assign miss = bus.dcache_req_i && !bus.dcache_hit_i;

    // Register x0 is hardwired to zero, so a load to it never creates a hazard.
    assign hazard = bus.ex_memread_i && (bus.ex_rd_i != 5'd0) &&
                    ((bus.ex_rd_i == bus.id_rs1_i) || (bus.ex_rd_i == bus.id_rs2_i));

    assign timeout = (state_q == REQ) && !bus.mem_ack_i && (wait_q == WAIT_LAST);

    // Any non-IDLE encoding (including the unused one) freezes the pipeline
    // until the FSM has recovered to IDLE.
    assign mem_stall = (state_q != IDLE) || miss;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                // A timed-out request is reissued after its one idle cycle.
                if (miss || retry_q) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.mem_ack_i) begin
                    state_d = FILL;
                end else if (timeout) begin
                    state_d = IDLE;
                end
            end
            FILL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Wait counter is held at zero outside REQ so every REQ entry starts at 0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wait_q <= 8'd0;
        end else if (state_q != REQ) begin
            wait_q <= 8'd0;
        end else if (!bus.mem_ack_i) begin
            wait_q <= wait_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            retry_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            retry_q <= timeout;
            if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= 16'd0;
        end else if ((mem_stall || hazard) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    // Pipeline control, zero-latency. Priority: mem stall > load-use > branch.
    // A branch coinciding with a hazard is not flushed; the ID instruction is
    // held and the branch resolves again next cycle.
    always_comb begin
        bus.pc_write_o    = 1'b1;
        bus.ifid_stall_o  = 1'b0;
        bus.ifid_flush_o  = 1'b0;
        bus.idex_bubble_o = 1'b0;
        if (mem_stall) begin
            bus.pc_write_o   = 1'b0;
            bus.ifid_stall_o = 1'b1;
        end else if (hazard) begin
            bus.pc_write_o    = 1'b0;
            bus.ifid_stall_o  = 1'b1;
            bus.idex_bubble_o = 1'b1;
        end else if (bus.branch_taken_i) begin
            bus.ifid_flush_o = 1'b1;
        end
    end

    assign bus.mem_req_o   = (state_q == REQ);
    assign bus.mem_stall_o = mem_stall;
    assign bus.state_o     = state_q;
    assign bus.stall_cnt_o = stall_cnt_q;
    assign bus.err_o       = err_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
// Bench for pipeline_hazard_ctrl built with TIMEOUT=4 so the retry path is
// reachable in a few cycles. Combinational priority cases come from a vector
// table; refill, timeout, reset and counter saturation use short sequences.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned TB_TIMEOUT = 4;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       exmr;
        logic [4:0] exrd;
        logic       br;
        logic       dreq;
        logic       dhit;
        logic       ack;
    } in_t;

    typedef struct packed {
        logic [1:0]  state;
        logic        mem_req;
        logic        mem_stall;
        logic [3:0]  ctl;        // {pc_write, ifid_stall, ifid_flush, idex_bubble}
        logic        err;
        logic [15:0] cnt;
    } obs_t;

    localparam int W = $bits(obs_t);

    typedef struct packed {
        in_t  in;
        obs_t exp;
    } vec_t;

    localparam logic [3:0] CTL_RUN    = 4'b1000;
    localparam logic [3:0] CTL_FREEZE = 4'b0100;
    localparam logic [3:0] CTL_HAZ    = 4'b0101;
    localparam logic [3:0] CTL_FLUSH  = 4'b1010;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;
    logic [W-1:0] exp_q[$];

    pipeline_hazard_ctrl_if bus();

    pipeline_hazard_ctrl #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    function automatic in_t mk_in(input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic exmr, input logic [4:0] exrd,
                                  input logic br, input logic dreq,
                                  input logic dhit, input logic ack);
        in_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.exmr = exmr; v.exrd = exrd;
        v.br = br; v.dreq = dreq; v.dhit = dhit; v.ack = ack;
        return v;
    endfunction

    function automatic obs_t mk_obs(input logic [1:0] state, input logic mem_req,
                                    input logic mem_stall, input logic [3:0] ctl,
                                    input logic err, input logic [15:0] cnt);
        obs_t o;
        o.state = state; o.mem_req = mem_req; o.mem_stall = mem_stall;
        o.ctl = ctl; o.err = err; o.cnt = cnt;
        return o;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input in_t v);
        bus.id_rs1_i       = v.rs1;
        bus.id_rs2_i       = v.rs2;
        bus.ex_memread_i   = v.exmr;
        bus.ex_rd_i        = v.exrd;
        bus.branch_taken_i = v.br;
        bus.dcache_req_i   = v.dreq;
        bus.dcache_hit_i   = v.dhit;
        bus.mem_ack_i      = v.ack;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check_out(input string name);
        obs_t act;
        obs_t exp;
        act.state     = bus.state_o;
        act.mem_req   = bus.mem_req_o;
        act.mem_stall = bus.mem_stall_o;
        act.ctl       = {bus.pc_write_o, bus.ifid_stall_o, bus.ifid_flush_o, bus.idex_bubble_o};
        act.err       = bus.err_o;
        act.cnt       = bus.stall_cnt_o;
        tests_run++;
        if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL %s: no expected entry queued, got state=%0d", name, act.state);
        end else begin
            exp = obs_t'(exp_q.pop_front());
            if (act !== exp) begin
                tests_failed++;
                $display("FAIL %s: got state=%0d req=%b mstall=%b ctl=%b err=%b cnt=%h, expected state=%0d req=%b mstall=%b ctl=%b err=%b cnt=%h",
                         name, act.state, act.mem_req, act.mem_stall, act.ctl, act.err, act.cnt,
                         exp.state, exp.mem_req, exp.mem_stall, exp.ctl, exp.err, exp.cnt);
            end
        end
    endtask

    // Called just after a rising edge; applies inputs for one cycle, checks
    // at the falling edge and returns just after the next rising edge.
    task automatic cycle(input in_t v, input obs_t e, input string name);
        drive(v);
        exp_q.push_back(W'(e));
        @(negedge clk);
        check_out(name);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(mk_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // ---------------- test body ----------------
    initial begin
        vec_t vecs[13];
        in_t  idle_in;
        in_t  haz_in;
        in_t  miss_in;
        in_t  ack_in;
        in_t  hit_in;
        in_t  br_in;
        in_t  hb_in;
        logic [1:0] st;

        tests_run    = 0;
        tests_failed = 0;

        idle_in = mk_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        haz_in  = mk_in(5'd1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        miss_in = mk_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        ack_in  = mk_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        hit_in  = mk_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        br_in   = mk_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        hb_in   = mk_in(5'd1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);

        // {inputs, expected outputs} from IDLE with the counter at zero.
        vecs[0]  = '{mk_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0), mk_obs(2'd0, 1'b0, 1'b0, CTL_RUN,    1'b0, 16'd0)};
        vecs[1]  = '{mk_in(5'd3, 5'd9, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0), mk_obs(2'd0, 1'b0, 1'b0, CTL_HAZ,    1'b0, 16'd0)};
        vecs[2]  = '{mk_in(5'd4, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0), mk_obs(2'd0, 1'b0, 1'b0, CTL_HAZ,    1'b0, 16'd0)};
        vecs[3]  = '{mk_in(5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0), mk_obs(2'd0, 1'b0, 1'b0, CTL_RUN,    1'b0, 16'd0)};
        vecs[4]  = '{mk_in(5'd7, 5'd2, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0), mk_obs(2'd0, 1'b0, 1'b0, CTL_RUN,    1'b0, 16'd0)};
        vecs[5]  = '{mk_in(5'd6, 5'd8, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0), mk_obs(2'd0, 1'b0, 1'b0, CTL_RUN,    1'b0, 16'd0)};
        vecs[6]  = '{mk_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0), mk_obs(2'd0, 1'b0, 1'b0, CTL_FLUSH,  1'b0, 16'd0)};
        vecs[7]  = '{mk_in(5'd31,5'd2, 1'b1, 5'd31,1'b1, 1'b0, 1'b0, 1'b0), mk_obs(2'd0, 1'b0, 1'b0, CTL_HAZ,    1'b0, 16'd0)};
        vecs[8]  = '{mk_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0), mk_obs(2'd0, 1'b0, 1'b1, CTL_FREEZE, 1'b0, 16'd0)};
        vecs[9]  = '{mk_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0), mk_obs(2'd0, 1'b0, 1'b0, CTL_RUN,    1'b0, 16'd0)};
        vecs[10] = '{mk_in(5'd1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0), mk_obs(2'd0, 1'b0, 1'b1, CTL_FREEZE, 1'b0, 16'd0)};
        vecs[11] = '{mk_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1), mk_obs(2'd0, 1'b0, 1'b0, CTL_RUN,    1'b0, 16'd0)};
        vecs[12] = '{mk_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0), mk_obs(2'd0, 1'b0, 1'b0, CTL_FLUSH,  1'b0, 16'd0)};

        // Reset state while rst is held.
        drive(idle_in);
        rst = 1'b1;
        exp_q.push_back(W'(mk_obs(2'd0, 1'b0, 1'b0, CTL_RUN, 1'b0, 16'd0)));
        @(negedge clk);
        check_out("reset_state");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table: inputs return to idle before each rising edge, so the FSM
        // and counter stay put and only the combinational path is checked.
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].in);
            exp_q.push_back(W'(vecs[i].exp));
            @(negedge clk);
            check_out($sformatf("vec%0d", i));
            drive(idle_in);
            @(posedge clk);
            #1;
        end

        // Load-use for one cycle.
        do_reset();
        cycle(haz_in,  mk_obs(2'd0, 1'b0, 1'b0, CTL_HAZ, 1'b0, 16'd0), "loaduse");
        cycle(idle_in, mk_obs(2'd0, 1'b0, 1'b0, CTL_RUN, 1'b0, 16'd1), "loaduse_after");

        // Miss with ack in cycle 3.
        do_reset();
        cycle(miss_in, mk_obs(2'd0, 1'b0, 1'b1, CTL_FREEZE, 1'b0, 16'd0), "miss_c0");
        cycle(miss_in, mk_obs(2'd1, 1'b1, 1'b1, CTL_FREEZE, 1'b0, 16'd1), "miss_c1");
        cycle(miss_in, mk_obs(2'd1, 1'b1, 1'b1, CTL_FREEZE, 1'b0, 16'd2), "miss_c2");
        cycle(ack_in,  mk_obs(2'd1, 1'b1, 1'b1, CTL_FREEZE, 1'b0, 16'd3), "miss_c3");
        cycle(miss_in, mk_obs(2'd2, 1'b0, 1'b1, CTL_FREEZE, 1'b0, 16'd4), "miss_c4");
        cycle(hit_in,  mk_obs(2'd0, 1'b0, 1'b0, CTL_RUN,    1'b0, 16'd5), "miss_c5");

        // Hazard + branch, then branch alone.
        do_reset();
        cycle(hb_in,   mk_obs(2'd0, 1'b0, 1'b0, CTL_HAZ,   1'b0, 16'd0), "hb_c0");
        cycle(br_in,   mk_obs(2'd0, 1'b0, 1'b0, CTL_FLUSH, 1'b0, 16'd1), "hb_c1");
        cycle(idle_in, mk_obs(2'd0, 1'b0, 1'b0, CTL_RUN,   1'b0, 16'd1), "hb_c2");

        // Ack never comes: REQ for TB_TIMEOUT cycles, one IDLE cycle, retry.
        do_reset();
        for (int k = 0; k <= 10; k++) begin
            st = (k == 0 || k == 5 || k == 10) ? 2'd0 : 2'd1;
            cycle(miss_in, mk_obs(st, st == 2'd1, 1'b1, CTL_FREEZE, k >= 5, 16'(k)),
                  $sformatf("timeout_c%0d", k));
        end

        // Now in REQ again: reset mid-cycle, away from any clock edge.
        drive(idle_in);
        #1;
        rst = 1'b1;
        #1;
        exp_q.push_back(W'(mk_obs(2'd0, 1'b0, 1'b0, CTL_RUN, 1'b0, 16'd0)));
        check_out("async_reset");
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        cycle(idle_in, mk_obs(2'd0, 1'b0, 1'b0, CTL_RUN, 1'b0, 16'd0), "post_reset");

        // Counter saturation under a sustained hazard.
        do_reset();
        drive(haz_in);
        repeat (65534) @(posedge clk);
        #1;
        exp_q.push_back(W'(mk_obs(2'd0, 1'b0, 1'b0, CTL_HAZ, 1'b0, 16'hFFFE)));
        @(negedge clk);
        check_out("sat_near");
        @(posedge clk);
        #1;
        cycle(haz_in, mk_obs(2'd0, 1'b0, 1'b0, CTL_HAZ, 1'b0, 16'hFFFF), "sat_reach");
        repeat (3) @(posedge clk);
        #1;
        cycle(haz_in, mk_obs(2'd0, 1'b0, 1'b0, CTL_HAZ, 1'b0, 16'hFFFF), "sat_hold");

        if (exp_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
